dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Memory-access stage directly downstream of the core's load/store byte-lane decoder.
- Takes a lane-aligned request (byte write enables, shifted store data, address) and routes it to the synchronous data BRAM or the MMIO bus.
- Returns the raw 32-bit read word, which the decoder consumes for load extraction.
- Handles BRAM 1-cycle read latency and variable-latency MMIO handshakes; stalls the pipeline via req_ready.

Parameters:
- DMEM_AW, 14, BRAM word-address width; dmem_addr = req_addr[DMEM_AW+1:2].
- IO_NIB, 4'h8, req_addr[31:28] value selecting the MMIO region.
- DMEM_NIB0, 4'h1, first req_addr[31:28] value selecting BRAM.
- DMEM_NIB1, 4'h3, second req_addr[31:28] value selecting BRAM.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_we  in  4  byte write enables, already lane-shifted; nonzero = store.
- req_re  in  1  load request.
- req_size  in  2  access size: 0 byte, 1 half, 2 word.
- req_addr  in  32  byte address.
- req_wdata  in  32  lane-shifted store data.
- dmem_en  out  1  BRAM enable.
- dmem_we  out  4  BRAM byte write enables.
- dmem_addr  out  DMEM_AW  BRAM word address.
- dmem_din  out  32  BRAM write data.
- dmem_dout  in  32  BRAM read data, valid one cycle after dmem_en.
- io_valid  out  1  MMIO request.
- io_we  out  4  MMIO byte write enables.
- io_addr  out  32  MMIO address.
- io_wdata  out  32  MMIO write data.
- io_ready  in  1  MMIO completion.
- io_rdata  in  32  MMIO read data, valid with io_ready.
- resp_valid  out  1  load response valid, one-cycle pulse.
- resp_data  out  32  raw load word.
- resp_fault  out  1  misaligned access flag.
- busy  out  1  high while in IO_WAIT.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - resp_valid, resp_data, resp_fault, io_valid, io_we, io_addr and io_wdata are cleared to 0.
  - An in-flight MMIO transaction is abandoned and io_valid drops immediately.
- States: IDLE, DRD (BRAM read response), IO_WAIT, IO_RESP, ZRD (unmapped read response).
- req_ready:
  - Equals 1 in IDLE, DRD, IO_RESP and ZRD.
  - Equals 0 in IO_WAIT.
- Accept: req_valid and req_ready.
  - Store priority: if req_we is nonzero, the request is a store and req_re is ignored.
  - No-op: req_we == 0 and req_re == 0 is accepted as a no-op with no response.
- BRAM store:
  - dmem_en = 1 and dmem_we = req_we combinationally in the accept cycle.
  - Next state IDLE; no response.
- BRAM load:
  - dmem_en = 1 and dmem_we = 0 in the accept cycle.
  - Next state DRD. In DRD: resp_valid = 1 and resp_data = dmem_dout.
  - DRD may accept a new request in the same cycle, giving one load per cycle throughput.
- MMIO access:
  - Accept registers io_addr, io_we and io_wdata, sets io_valid, and moves to IO_WAIT.
  - io_* signals are held stable until io_ready.
  - io_ready in IO_WAIT:
    - Load: capture io_rdata, move to IO_RESP (resp_valid = 1, resp_data = captured word).
    - Store: move to IDLE.
  - io_valid deasserts the cycle after io_ready.
- Unmapped address:
  - Store: dropped.
  - Load: move to ZRD, which returns resp_valid = 1 with resp_data = 0.
- Response states: from DRD, IO_RESP and ZRD, the next state follows any newly accepted request, else IDLE.
- resp_valid is never high for more than one cycle per load.
- dmem_en and dmem_we are 0 in any cycle without an accepted BRAM request.
- Address wrap: addresses beyond the BRAM depth alias modulo 2^DMEM_AW words.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- With the macro defined:
  - Misaligned accesses are half with req_addr[0] = 1, or word with req_addr[1:0] != 0.
  - A misaligned access performs no BRAM or MMIO access.
  - It is answered in ZRD-style next cycle with resp_valid = 1, resp_fault = 1, resp_data = 0. This applies to stores too.
- Without the macro:
  - resp_fault is tied to 0 and req_size is unused.
  - Accesses use the word address; the low address bits are ignored.

Test Plan:
- Store then load to BRAM: store addr 0x10000010, we 4'b1111, wdata 0xDEADBEEF; then load addr 0x10000010 -> dmem_addr = 4, next cycle resp_valid = 1, resp_data = 0xDEADBEEF.
- Back-to-back BRAM loads at 0x10000000 and 0x10000004 on consecutive cycles -> req_ready stays 1; resp_valid on two consecutive cycles with the correct words.
- MMIO load at 0x80000008 with io_ready after 3 cycles and io_rdata 0x55 -> req_ready = 0 and busy = 1 for 3 cycles; then resp_valid = 1 with resp_data = 0x55 one cycle after io_ready.
- Reset mid-IO: assert rst low in IO_WAIT -> io_valid = 0 and resp_valid = 0 immediately; after release, state is IDLE and req_ready = 1.
- Unmapped load at 0x50000000 -> no dmem_en or io_valid; next cycle resp_valid = 1, resp_data = 0. An unmapped store produces no response.
- With DMEM_MISALIGN_TRAP_EN: word load at 0x10000002 -> dmem_en = 0; next cycle resp_fault = 1, resp_data = 0.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Memory-access stage: routes lane-aligned load/store requests to the data BRAM or the MMIO bus.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned accesses answered with resp_fault).
module dmem_access_ctrl #(
    parameter int         DMEM_AW   = 14,
    parameter logic [3:0] IO_NIB    = 4'h8,
    parameter logic [3:0] DMEM_NIB0 = 4'h1,
    parameter logic [3:0] DMEM_NIB1 = 4'h3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_we,
    input  logic               req_re,
    input  logic [1:0]         req_size,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_din,
    input  logic [31:0]        dmem_dout,
    output logic               io_valid,
    output logic [3:0]         io_we,
    output logic [31:0]        io_addr,
    output logic [31:0]        io_wdata,
    input  logic               io_ready,
    input  logic [31:0]        io_rdata,
    output logic               resp_valid,
    output logic [31:0]        resp_data,
    output logic               resp_fault,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRD     = 3'd1,
        S_IO_WAIT = 3'd2,
        S_IO_RESP = 3'd3,
        S_ZRD     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_io_valid;
    logic [3:0]  r_io_we;
    logic [31:0] r_io_addr;
    logic [31:0] r_io_wdata;
    logic        r_io_load;
    logic [31:0] r_io_rdata;

    logic        w_accept;
    logic        w_is_store;
    logic        w_is_load;
    logic        w_access;
    logic        w_is_dmem;
    logic        w_is_io;
    logic        w_misalign;
    logic        w_dmem_en;
    logic [3:0]  w_dmem_we;
    logic        w_io_start;

    assign req_ready  = (r_state != S_IO_WAIT);
    assign busy       = (r_state == S_IO_WAIT);
    assign w_accept   = req_valid & req_ready;
    // A nonzero byte-enable mask makes the request a store regardless of req_re.
    assign w_is_store = |req_we;
    assign w_is_load  = ~w_is_store & req_re;
    assign w_access   = w_is_store | w_is_load;
    assign w_is_dmem  = (req_addr[31:28] == DMEM_NIB0) || (req_addr[31:28] == DMEM_NIB1);
    assign w_is_io    = (req_addr[31:28] == IO_NIB);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, req_addr[27:DMEM_AW+2]};
`else
    assign w_misalign = 1'b0;
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, req_size, req_addr[1:0], req_addr[27:DMEM_AW+2]};
`endif

    assign dmem_en   = w_dmem_en;
    assign dmem_we   = w_dmem_we;
    assign dmem_addr = req_addr[DMEM_AW+1:2];
    assign dmem_din  = req_wdata;

    assign io_valid = r_io_valid;
    assign io_we    = r_io_we;
    assign io_addr  = r_io_addr;
    assign io_wdata = r_io_wdata;

    // Next-state decode and BRAM strobes for the accept cycle.
    always_comb begin
        w_next_state = r_state;
        w_dmem_en    = 1'b0;
        w_dmem_we    = 4'b0000;
        w_io_start   = 1'b0;
        case (r_state)
            S_IO_WAIT: begin
                if (io_ready) begin
                    if (r_io_load) begin
                        w_next_state = S_IO_RESP;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_state = S_IO_WAIT;
                end
            end
            S_IDLE, S_DRD, S_IO_RESP, S_ZRD: begin
                if (w_accept && w_access) begin
                    if (w_misalign) begin
                        w_next_state = S_ZRD;
                    end else if (w_is_dmem) begin
                        w_dmem_en = 1'b1;
                        w_dmem_we = req_we;
                        if (w_is_load) begin
                            w_next_state = S_DRD;
                        end else begin
                            w_next_state = S_IDLE;
                        end
                    end else if (w_is_io) begin
                        w_io_start   = 1'b1;
                        w_next_state = S_IO_WAIT;
                    end else if (w_is_load) begin
                        w_next_state = S_ZRD;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register and MMIO request/capture registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_io_valid <= 1'b0;
            r_io_we    <= 4'b0000;
            r_io_addr  <= 32'h0000_0000;
            r_io_wdata <= 32'h0000_0000;
            r_io_load  <= 1'b0;
            r_io_rdata <= 32'h0000_0000;
        end else begin
            r_state <= w_next_state;
            if (w_io_start) begin
                r_io_valid <= 1'b1;
                r_io_we    <= req_we;
                r_io_addr  <= req_addr;
                r_io_wdata <= req_wdata;
                r_io_load  <= w_is_load;
            end else if (r_io_valid && io_ready) begin
                r_io_valid <= 1'b0;
            end else begin
                r_io_valid <= r_io_valid;
            end
            if ((r_state == S_IO_WAIT) && io_ready && r_io_load) begin
                r_io_rdata <= io_rdata;
            end else begin
                r_io_rdata <= r_io_rdata;
            end
        end
    end

    // Response mux: each response state lasts exactly one cycle.
    always_comb begin
        resp_valid = 1'b0;
        resp_data  = 32'h0000_0000;
        case (r_state)
            S_DRD: begin
                resp_valid = 1'b1;
                resp_data  = dmem_dout;
            end
            S_IO_RESP: begin
                resp_valid = 1'b1;
                resp_data  = r_io_rdata;
            end
            S_ZRD: begin
                resp_valid = 1'b1;
                resp_data  = 32'h0000_0000;
            end
            default: begin
                resp_valid = 1'b0;
                resp_data  = 32'h0000_0000;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_fault;

    // Fault flag accompanies the ZRD response that follows a trapped access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_accept & w_access & w_misalign;
        end
    end

    assign resp_fault = r_fault;
`else
    assign resp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed test-plan cases plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_we;
    logic        req_re;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_din;
    logic [31:0] dmem_dout;
    logic        io_valid;
    logic [3:0]  io_we;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_ready;
    logic [31:0] io_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic        busy;

    dmem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_re(req_re),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
        .dmem_dout(dmem_dout),
        .io_valid(io_valid), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ready(io_ready), .io_rdata(io_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // Environment BRAM: synchronous, one-cycle read latency, byte writes.
    logic [31:0] tb_mem [0:16383];
    always @(posedge clk) begin
        if (dmem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_we[b]) tb_mem[dmem_addr][8*b +: 8] <= dmem_din[8*b +: 8];
            end
            dmem_dout <= tb_mem[dmem_addr];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:16383];
    bit          m_pend, m_pio_load;
    logic [31:0] m_pio_addr, m_pio_wdata;
    logic [3:0]  m_pio_we;
    bit          m_rv, m_rf;
    logic [31:0] m_rd;

    // MMIO responder controls
    int  io_cnt, io_lat;
    bit  io_fixed, rdata_fix;

    // Last-cycle samples for the literal checks
    logic        s_ready, s_busy, s_dmem_en, s_io_valid, s_resp_valid, s_resp_fault;
    logic [13:0] s_dmem_addr;
    logic [31:0] s_resp_data;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 1'b0; m_pio_load = 1'b0; m_rv = 1'b0; m_rf = 1'b0; m_rd = 32'h0;
        io_cnt = 0;
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic cycle(input bit v, input logic [3:0] we, input bit re, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd);
        bit acc, st, ld, mis, in_dmem, in_io, exp_en, n_rv, n_rf;
        logic [31:0] n_rd;
        logic [13:0] idx;
        @(negedge clk);
        req_valid = v; req_we = we; req_re = re; req_size = sz; req_addr = addr; req_wdata = wd;
        if (io_valid) begin
            if (io_cnt == 0 && !io_fixed) io_lat = $urandom_range(0, 4);
            io_ready = (io_cnt >= io_lat);
            io_rdata = rdata_fix ? 32'h0000_0055 : $urandom;
        end else begin
            io_ready = 1'b0;
            io_rdata = $urandom;
        end
        #1;
        st      = (we != 4'b0000);
        ld      = !st && re;
        acc     = v && !m_pend;
        in_dmem = (addr[31:28] == 4'h1) || (addr[31:28] == 4'h3);
        in_io   = (addr[31:28] == 4'h8);
        idx     = addr[15:2];
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        exp_en = acc && in_dmem && (st || ld) && !mis;

        chk("req_ready", {31'b0, req_ready}, {31'b0, !m_pend});
        chk("busy", {31'b0, busy}, {31'b0, m_pend});
        chk("dmem_en", {31'b0, dmem_en}, {31'b0, exp_en});
        chk("dmem_we", {28'b0, dmem_we}, {28'b0, (exp_en && st) ? we : 4'b0000});
        if (exp_en) chk("dmem_addr", {18'b0, dmem_addr}, {18'b0, idx});
        if (exp_en && st) chk("dmem_din", dmem_din, wd);
        chk("io_valid", {31'b0, io_valid}, {31'b0, m_pend});
        if (m_pend) begin
            chk("io_addr", io_addr, m_pio_addr);
            chk("io_we", {28'b0, io_we}, {28'b0, m_pio_we});
            chk("io_wdata", io_wdata, m_pio_wdata);
        end
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_rv});
        if (m_rv) chk("resp_data", resp_data, m_rd);
        chk("resp_fault", {31'b0, resp_fault}, {31'b0, m_rf});

        s_ready = req_ready; s_busy = busy; s_dmem_en = dmem_en; s_io_valid = io_valid;
        s_resp_valid = resp_valid; s_resp_data = resp_data; s_resp_fault = resp_fault;
        s_dmem_addr = dmem_addr;

        n_rv = 1'b0; n_rf = 1'b0; n_rd = 32'h0;
        if (m_pend) begin
            if (io_ready) begin
                m_pend = 1'b0;
                if (m_pio_load) begin n_rv = 1'b1; n_rd = io_rdata; end
            end
        end else if (acc && (st || ld)) begin
            if (mis) begin
                n_rv = 1'b1; n_rf = 1'b1;
            end else if (in_dmem) begin
                if (st) begin
                    for (int b = 0; b < 4; b++)
                        if (we[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    n_rv = 1'b1; n_rd = ref_mem[idx];
                end
            end else if (in_io) begin
                m_pend = 1'b1; m_pio_load = ld; m_pio_addr = addr; m_pio_we = we; m_pio_wdata = wd;
            end else if (ld) begin
                n_rv = 1'b1;
            end
        end
        m_rv = n_rv; m_rf = n_rf; m_rd = n_rd;
        if (io_valid && !io_ready) io_cnt++;
        else io_cnt = 0;
    endtask

    task automatic idle();
        cycle(1'b0, 4'b0000, 1'b0, 2'd2, 32'h0, 32'h0);
    endtask

    initial begin
        int busy_cnt;
        logic [3:0] nib;
        logic [3:0] rwe;
        rst = 1'b0; req_valid = 1'b0; req_we = 4'b0; req_re = 1'b0; req_size = 2'd0;
        req_addr = 32'h0; req_wdata = 32'h0; io_ready = 1'b0; io_rdata = 32'h0;
        io_fixed = 1'b0; rdata_fix = 1'b0; io_lat = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("reset_io_valid", {31'b0, io_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        idle();

        // Store then load to BRAM
        cycle(1'b1, 4'b1111, 1'b0, 2'd2, 32'h1000_0010, 32'hDEAD_BEEF);
        cycle(1'b1, 4'b0000, 1'b1, 2'd2, 32'h1000_0010, 32'h0);
        chk("lit_dmem_addr", {18'b0, s_dmem_addr}, 32'd4);
        idle();
        chk("lit_load_valid", {31'b0, s_resp_valid}, 32'd1);
        chk("lit_load_data", s_resp_data, 32'hDEAD_BEEF);

        // Back-to-back BRAM loads
        cycle(1'b1, 4'b1111, 1'b0, 2'd2, 32'h1000_0000, 32'h1111_1111);
        cycle(1'b1, 4'b1111, 1'b0, 2'd2, 32'h1000_0004, 32'h2222_2222);
        cycle(1'b1, 4'b0000, 1'b1, 2'd2, 32'h1000_0000, 32'h0);
        cycle(1'b1, 4'b0000, 1'b1, 2'd2, 32'h1000_0004, 32'h0);
        chk("lit_b2b_ready", {31'b0, s_ready}, 32'd1);
        chk("lit_b2b_data0", s_resp_data, 32'h1111_1111);
        idle();
        chk("lit_b2b_data1", s_resp_data, 32'h2222_2222);

        // MMIO load, io_ready on the third waiting cycle
        io_fixed = 1'b1; io_lat = 2; rdata_fix = 1'b1;
        cycle(1'b1, 4'b0000, 1'b1, 2'd2, 32'h8000_0008, 32'h0);
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (s_busy) busy_cnt++;
        end
        chk("lit_io_busy_cycles", busy_cnt, 32'd3);
        chk("lit_io_resp_valid", {31'b0, s_resp_valid}, 32'd1);
        chk("lit_io_resp_data", s_resp_data, 32'h0000_0055);
        rdata_fix = 1'b0;

        // Reset while waiting on MMIO
        io_lat = 10;
        cycle(1'b1, 4'b0000, 1'b1, 2'd2, 32'h8000_0000, 32'h0);
        idle();
        @(negedge clk);
        req_valid = 1'b0; io_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_io_valid", {31'b0, io_valid}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_release_ready", {31'b0, req_ready}, 32'd1);
        io_fixed = 1'b0;
        idle();

        // Unmapped load and store
        cycle(1'b1, 4'b0000, 1'b1, 2'd2, 32'h5000_0000, 32'h0);
        chk("lit_unmap_dmem_en", {31'b0, s_dmem_en}, 32'd0);
        chk("lit_unmap_io_valid", {31'b0, s_io_valid}, 32'd0);
        cycle(1'b1, 4'b1111, 1'b0, 2'd2, 32'h5000_0004, 32'h1234_5678);
        chk("lit_unmap_ld_valid", {31'b0, s_resp_valid}, 32'd1);
        chk("lit_unmap_ld_data", s_resp_data, 32'h0);
        idle();
        chk("lit_unmap_st_noresp", {31'b0, s_resp_valid}, 32'd0);

`ifdef DMEM_MISALIGN_TRAP_EN
        cycle(1'b1, 4'b0000, 1'b1, 2'd2, 32'h1000_0002, 32'h0);
        chk("lit_mis_dmem_en", {31'b0, s_dmem_en}, 32'd0);
        idle();
        chk("lit_mis_fault", {31'b0, s_resp_fault}, 32'd1);
        chk("lit_mis_data", s_resp_data, 32'h0);
`endif

        // Initialise the random-test BRAM window (16 words, aliased through upper bits)
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 4'b1111, 1'b0, 2'd2, {4'h1, 12'h000, 10'b0, i[3:0], 2'b00}, $urandom);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: nib = 4'h1;
                3, 4:    nib = 4'h3;
                5, 6:    nib = 4'h8;
                default: nib = 4'($urandom);
            endcase
            rwe = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            cycle(($urandom_range(0, 3) != 0), rwe, 1'($urandom), 2'($urandom_range(0, 2)),
                  {nib, 12'($urandom), 10'b0, 4'($urandom), 2'($urandom)}, $urandom);
        end
        repeat (8) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
